// File: rtl/pwm_pkg.sv
// pwm_pkg: shared default widths and ramp sequencer state encoding
package pwm_pkg;
  localparam int DW_DEF = 16;
  localparam int HW_DEF = 8;
  typedef enum logic [1:0] {IDLE, RAMP, STEADY, STOPPING} pwm_ramp_state_e;
endpackage

// File: rtl/pwm_presc.sv
// pwm_presc: free-running prescaler producing a registered one-cycle clock-enable tick
module pwm_presc (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] CFG_PRESC,
  output logic        PWM_CLKE
);
  logic [15:0] pre_cnt;
  // wrap on >= so lowering PRESC below the running count wraps at once instead of stalling
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      pre_cnt  <= '0;
      PWM_CLKE <= 1'b0;
    end else begin
      PWM_CLKE <= pre_cnt >= CFG_PRESC;
      pre_cnt  <= pre_cnt >= CFG_PRESC ? '0 : pre_cnt + 16'd1;
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequences one pwm_ch, ramping its duty toward a target once per N periods
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int HW = HW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [15:0]   CFG_PRESC,
  input  logic [DW-1:0] CFG_PERIOD,
  input  logic [DW-1:0] CFG_TARGET,
  input  logic [DW-1:0] CFG_STEP,
  input  logic [HW-1:0] CFG_HOLD,
  input  logic          CMD_START,
  input  logic          CMD_STOP,
  output logic          PWM_CLKE,
  output logic          PWM_EN,
  output logic [DW-1:0] PWM_PERIOD,
  output logic [DW-1:0] PWM_DUTY,
  output logic          BUSY,
  output logic          DONE
);
  localparam logic [DW-1:0] ONE = 1;
  localparam logic [HW-1:0] HONE = 1;
  pwm_ramp_state_e state;
  logic [DW-1:0] target, step, per_cnt, diff, stepped;
  logic [HW-1:0] hold, hold_cnt;
  logic armed, per_end, arrive, up, start_ok, stop_ok;

  pwm_presc u_presc (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CFG_PRESC(CFG_PRESC),
    .PWM_CLKE (PWM_CLKE)
  );

  assign per_end  = PWM_CLKE && armed && per_cnt == PWM_PERIOD;
  assign stop_ok  = CMD_STOP && (state == RAMP || state == STEADY);
  assign start_ok = CMD_START && !CMD_STOP && state != STOPPING;

  // mirror of the channel counter; the first tick after enable is the channel's latch tick
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      per_cnt <= '0;
      armed   <= 1'b0;
    end else if (!PWM_EN) begin
      per_cnt <= '0;
      armed   <= 1'b0;
    end else if (PWM_CLKE) begin
      armed   <= 1'b1;
      per_cnt <= (!armed || per_cnt == PWM_PERIOD) ? '0 : per_cnt + ONE;
    end

  // next duty one step toward target, landing exactly on target when within reach
  always_comb begin
    up      = target >= PWM_DUTY;
    diff    = up ? target - PWM_DUTY : PWM_DUTY - target;
    stepped = (step == '0 || diff <= step) ? target : (up ? PWM_DUTY + step : PWM_DUTY - step);
  end

  // sequencer: accept commands, step duty on period ends, shut the channel down on stop
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state      <= IDLE;
      PWM_EN     <= 1'b0;
      PWM_PERIOD <= '0;
      PWM_DUTY   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      target     <= '0;
      step       <= '0;
      hold       <= '0;
      hold_cnt   <= '0;
      arrive     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (stop_ok) begin
        state  <= STOPPING;
        BUSY   <= 1'b1;
        arrive <= 1'b0;
      end else if (start_ok) begin
        if (state == IDLE) begin
          PWM_PERIOD <= CFG_PERIOD;
          PWM_EN     <= 1'b1;
        end
        target   <= CFG_TARGET;
        step     <= CFG_STEP;
        hold     <= CFG_HOLD;
        hold_cnt <= '0;
        arrive   <= 1'b0;
        state    <= CFG_TARGET == PWM_DUTY ? STEADY : RAMP;
        BUSY     <= CFG_TARGET != PWM_DUTY;
        DONE     <= CFG_TARGET == PWM_DUTY;
      end else if (state == RAMP && arrive) begin
        state  <= STEADY;
        BUSY   <= 1'b0;
        DONE   <= 1'b1;
        arrive <= 1'b0;
      end else if (state == RAMP && per_end) begin
        hold_cnt <= hold_cnt == hold ? '0 : hold_cnt + HONE;
        if (hold_cnt == hold) begin
          PWM_DUTY <= stepped;
          arrive   <= stepped == target;
        end
      end else if (state == STOPPING && per_end) begin
        state    <= IDLE;
        PWM_EN   <= 1'b0;
        PWM_DUTY <= '0;
        BUSY     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed table-driven checks of prescaler, ramp stepping, stop and reset
module tb_pwm_ramp_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] cfg_presc = 16'd3, cfg_period = 16'd9, cfg_target = '0, cfg_step = '0;
  logic [7:0] cfg_hold = '0;
  logic cmd_start = 1'b0, cmd_stop = 1'b0;
  logic pwm_clke, pwm_en, busy, done;
  logic [15:0] pwm_period, pwm_duty;
  int checks = 0, errors = 0, done_cnt = 0;

  typedef struct packed {
    logic            sf;
    logic [15:0]     target;
    logic [15:0]     step;
    logic [7:0]      hold;
    logic [1:0]      n;
    logic [2:0][15:0] seq;
    logic [7:0]      lat;
  } ramp_t;
  ramp_t tbl [5];

  pwm_ramp_ctrl dut (
    .CLK(clk), .RST_N(rst_n), .CFG_PRESC(cfg_presc), .CFG_PERIOD(cfg_period),
    .CFG_TARGET(cfg_target), .CFG_STEP(cfg_step), .CFG_HOLD(cfg_hold),
    .CMD_START(cmd_start), .CMD_STOP(cmd_stop), .PWM_CLKE(pwm_clke), .PWM_EN(pwm_en),
    .PWM_PERIOD(pwm_period), .PWM_DUTY(pwm_duty), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic st, input logic sp);
    cmd_start = st;
    cmd_stop  = sp;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
  endtask

  task automatic wait_change(input logic [15:0] prev, output int cyc);
    cyc = 0;
    while (pwm_duty === prev && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (pwm_duty === prev) begin
      errors++;
      $display("FAIL duty_timeout: got %0d expected change from %0d", pwm_duty, prev);
    end
  endtask

  task automatic wait_en_low(output int cyc);
    cyc = 0;
    while (pwm_en !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (pwm_en !== 1'b0) begin
      errors++;
      $display("FAIL en_timeout: got %0d expected 0", pwm_en);
    end
  endtask

  initial begin
    int cyc, d0;
    logic [15:0] prev;
    tbl[0] = '{sf:1'b0, target:16'd6,   step:16'd2,  hold:8'd0, n:2'd3, seq:{16'd6, 16'd4, 16'd2},  lat:8'd12};
    tbl[1] = '{sf:1'b1, target:16'd5,   step:16'd2,  hold:8'd0, n:2'd3, seq:{16'd5, 16'd4, 16'd2},  lat:8'd12};
    tbl[2] = '{sf:1'b0, target:16'd1,   step:16'd3,  hold:8'd0, n:2'd2, seq:{16'd0, 16'd1, 16'd2},  lat:8'd0};
    tbl[3] = '{sf:1'b1, target:16'd100, step:16'd0,  hold:8'd2, n:2'd1, seq:{16'd0, 16'd0, 16'd100}, lat:8'd32};
    tbl[4] = '{sf:1'b0, target:16'd40,  step:16'd30, hold:8'd0, n:2'd2, seq:{16'd0, 16'd40, 16'd70}, lat:8'd0};

    repeat (2) @(negedge clk);
    chk("rst_clke", pwm_clke, 0);
    chk("rst_en", pwm_en, 0);
    chk("rst_period", pwm_period, 0);
    chk("rst_duty", pwm_duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("presc3_clke", pwm_clke, (i % 4) == 3);
    end
    cfg_presc = 16'd0;
    repeat (3) @(negedge clk);
    chk("presc0_clke", pwm_clke, 1);

    for (int r = 0; r < 5; r++) begin
      if (tbl[r].sf) begin
        pulse(1'b0, 1'b1);
        wait_en_low(cyc);
        chk("stop_duty", pwm_duty, 0);
        chk("stop_busy", busy, 0);
      end
      cfg_period = (tbl[r].sf || r == 0) ? 16'd9 : 16'd50;
      cfg_target = tbl[r].target;
      cfg_step   = tbl[r].step;
      cfg_hold   = tbl[r].hold;
      d0   = done_cnt;
      prev = pwm_duty;
      pulse(1'b1, 1'b0);
      cfg_target = 16'hFFFF;
      cfg_step   = 16'd1;
      cfg_hold   = 8'd0;
      cfg_period = 16'd3;
      chk("start_period", pwm_period, 9);
      chk("start_en", pwm_en, 1);
      chk("start_busy", busy, 1);
      for (int i = 0; i < int'(tbl[r].n); i++) begin
        wait_change(prev, cyc);
        if (i == 0 && tbl[r].lat != 0) chk("first_lat", cyc + 1, tbl[r].lat);
        if (i > 0) chk("step_gap", cyc, (tbl[r].hold + 1) * 10);
        chk("step_duty", pwm_duty, tbl[r].seq[i]);
        chk("step_busy", busy, 1);
        prev = pwm_duty;
      end
      @(negedge clk);
      chk("done_hi", done, 1);
      chk("busy_lo", busy, 0);
      @(negedge clk);
      chk("done_lo", done, 0);
      @(negedge clk);
      chk("done_pulses", done_cnt - d0, 1);
    end

    d0 = done_cnt;
    cfg_target = 16'd7;
    cfg_step   = 16'd1;
    pulse(1'b1, 1'b1);
    chk("stopping_busy", busy, 1);
    chk("stopping_en", pwm_en, 1);
    chk("stopping_duty", pwm_duty, 40);
    pulse(1'b1, 1'b0);
    wait_en_low(cyc);
    chk("stop_lat_ok", cyc <= 10, 1);
    chk("stopped_duty", pwm_duty, 0);
    chk("stopped_busy", busy, 0);
    repeat (25) @(negedge clk);
    chk("start_in_stopping_dropped", pwm_en, 0);
    chk("no_done_on_stop", done_cnt - d0, 0);
    pulse(1'b0, 1'b1);
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_en", pwm_en, 0);

    cfg_period = 16'd9;
    cfg_target = 16'd6;
    cfg_step   = 16'd2;
    cfg_hold   = 8'd0;
    pulse(1'b1, 1'b0);
    wait_change(16'd0, cyc);
    wait_change(16'd2, cyc);
    chk("pre_reset_duty", pwm_duty, 4);
    cfg_presc = 16'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("async_clke", pwm_clke, 0);
    chk("async_en", pwm_en, 0);
    chk("async_period", pwm_period, 0);
    chk("async_duty", pwm_duty, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_clke", pwm_clke, (i % 4) == 3);
    end
    chk("post_reset_en", pwm_en, 0);
    chk("post_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
